// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding, exception cause codes, and a helper giving the access size.
package lsu_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Request FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  // exc_cause encoding
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // Bytes touched by an access; the low two funct3 bits carry the size,
  // the top bit only selects zero-extension.
  function automatic logic [2:0] access_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational legality check for one memory op.
// Ports:
//   i_ea       effective address
//   i_funct3   RV32I width code
//   i_is_store 1 = store, 0 = load
//   o_fault    op must not reach memory
//   o_cause    illegal funct3 (11) > misaligned (01) > out of range (10)
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic [31:0] i_ea,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  output logic        o_fault,
  output logic [1:0]  o_cause
);

  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  logic [32:0] w_last;

  always_comb begin
    if (i_is_store)
      w_illegal = !(i_funct3 inside {F3_B, F3_H, F3_W});
    else
      w_illegal = !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    w_misalign = ((i_funct3[1:0] == 2'b01) && i_ea[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (i_ea[1:0] != 2'b00));

    // 33-bit sum so an access near 2^32 cannot wrap back into range
    w_last  = {1'b0, i_ea} + {30'b0, access_bytes(i_funct3)} - 33'd1;
    w_range = (w_last >= 33'(MEM_BYTES));

    o_fault = w_illegal || w_misalign || w_range;
    if (w_illegal)       o_cause = EXC_ILLEGAL;
    else if (w_misalign) o_cause = EXC_MISALIGN;
    else if (w_range)    o_cause = EXC_RANGE;
    else                 o_cause = EXC_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between EX and a combinational data
// memory. Legal ops spend one cycle in ACCESS driving the memory strobe;
// faulting ops skip memory and go straight to RESP with an exception.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request from EX (valid/ready)
//   mem_*                    data-memory request; mem_rdata is already extended
//   resp_*                   writeback response (valid/ready)
//   exc_*                    exception info, valid only alongside resp_valid
//   o_dbg_state              current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and payload stable until then, and the
// unit holds every resp_*/exc_* output stable while resp_valid waits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_we,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic [1:0]  o_dbg_state
);

  lsu_state_t  r_state;
  logic [31:0] r_ea;
  logic [2:0]  r_funct3;
  logic        r_is_store;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic [31:0] r_exc_addr;
  logic        r_resp_we;
  logic [31:0] r_resp_data;

  logic [31:0] w_ea;
  logic        w_fault;
  logic [1:0]  w_cause;
  logic        w_access;

  assign w_ea = req_base + req_offset;

  lsu_addr_check #(.MEM_BYTES(MEM_BYTES)) u_check (
    .i_ea       (w_ea),
    .i_funct3   (req_funct3),
    .i_is_store (req_is_store),
    .o_fault    (w_fault),
    .o_cause    (w_cause)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ea        <= '0;
      r_funct3    <= '0;
      r_is_store  <= 1'b0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_fault     <= 1'b0;
      r_cause     <= EXC_NONE;
      r_exc_addr  <= '0;
      r_resp_we   <= 1'b0;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ea        <= w_ea;
            r_funct3    <= req_funct3;
            r_is_store  <= req_is_store;
            r_wdata     <= req_wdata;
            r_rd        <= req_rd;
            r_resp_data <= '0;
            if (w_fault) begin
              r_fault    <= 1'b1;
              r_cause    <= w_cause;
              r_exc_addr <= w_ea;
              r_resp_we  <= 1'b0;
              r_state    <= ST_RESP;
            end else begin
              r_fault    <= 1'b0;
              r_cause    <= EXC_NONE;
              r_exc_addr <= '0;
              r_resp_we  <= !req_is_store && (req_rd != 5'd0);
              r_state    <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          r_resp_data <= r_is_store ? 32'd0 : mem_rdata;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are gated by rst directly so a reset landing mid-ACCESS kills
  // the write in that same cycle rather than one edge later.
  assign w_access   = (r_state == ST_ACCESS);
  assign mem_read   = w_access && !r_is_store && !rst;
  assign mem_write  = w_access &&  r_is_store && !rst;
  assign mem_addr   = w_access ? r_ea     : 32'd0;
  assign mem_wdata  = w_access ? r_wdata  : 32'd0;
  assign mem_funct3 = w_access ? r_funct3 : 3'd0;

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_data   = r_resp_data;
  assign resp_rd     = r_rd;
  assign resp_we     = r_resp_we;
  assign exc_valid   = resp_valid && r_fault;
  assign exc_cause   = r_cause;
  assign exc_addr    = r_exc_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory stub.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_funct3   (mem_funct3),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_we      (resp_we),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_addr     (exc_addr),
    .o_dbg_state  (o_dbg_state)
  );

  // memory stub: little-endian bytes, extended combinational read
  logic [7:0] mem [0:1023];
  logic [9:0] a0, a1, a2, a3;

  always_comb begin
    a0 = mem_addr[9:0];
    a1 = a0 + 10'd1;
    a2 = a0 + 10'd2;
    a3 = a0 + 10'd3;
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b100:  mem_rdata = {24'd0, mem[a0]};
      3'b101:  mem_rdata = {16'd0, mem[a1], mem[a0]};
      default: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op and check it at the fixed cycles the unit promises:
  // accept at edge N, strobe in N+1, response at N+2 (or N+1 when faulting).
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] off,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic exp_fault, input logic [1:0] exp_cause,
                        input logic [31:0] exp_ea, input logic [31:0] exp_data,
                        input logic exp_we);
    @(negedge clk);
    check({tag, "/ready"}, req_ready, 1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!exp_fault) begin
      check({tag, "/rd_strobe"}, mem_read, !st);
      check({tag, "/wr_strobe"}, mem_write, st);
      check({tag, "/mem_addr"}, mem_addr, exp_ea);
      check({tag, "/early_resp"}, resp_valid, 0);
      @(negedge clk);
    end
    check({tag, "/no_strobe"}, mem_read | mem_write, 0);
    check({tag, "/resp_valid"}, resp_valid, 1);
    check({tag, "/exc_valid"}, exc_valid, exp_fault);
    check({tag, "/exc_cause"}, exc_cause, exp_fault ? exp_cause : 2'b00);
    check({tag, "/exc_addr"}, exc_addr, exp_fault ? exp_ea : 32'd0);
    check({tag, "/resp_data"}, resp_data, exp_data);
    check({tag, "/resp_we"}, resp_we, exp_we);
    check({tag, "/resp_rd"}, resp_rd, rd);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "/back_idle"}, req_ready, 1);
    check({tag, "/resp_drop"}, resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_base = '0; req_offset = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst/req_ready", req_ready, 1);
    check("rst/resp_valid", resp_valid, 0);
    check("rst/exc_valid", exc_valid, 0);
    check("rst/resp_data", resp_data, 0);
    check("rst/resp_we", resp_we, 0);
    check("rst/strobes", mem_read | mem_write, 0);

    //     tag       st  f3      base          off           wdata         rd  flt cause  ea            data          we
    run_op("sw104",  1, 3'b010, 32'h100,      32'h4,        32'hDEADBEEF, 0,  0, 2'b00, 32'h104,      32'h0,        0);
    run_op("lw104",  0, 3'b010, 32'h100,      32'h4,        32'h0,        5,  0, 2'b00, 32'h104,      32'hDEADBEEF, 1);
    run_op("sb10",   1, 3'b000, 32'h10,       32'h0,        32'h12345680, 1,  0, 2'b00, 32'h10,       32'h0,        0);
    run_op("lb10",   0, 3'b000, 32'h10,       32'h0,        32'h0,        3,  0, 2'b00, 32'h10,       32'hFFFFFF80, 1);
    run_op("lbu10",  0, 3'b100, 32'h10,       32'h0,        32'h0,        3,  0, 2'b00, 32'h10,       32'h00000080, 1);
    run_op("lh106",  0, 3'b001, 32'h100,      32'h6,        32'h0,        6,  0, 2'b00, 32'h106,      32'hFFFFDEAD, 1);
    run_op("lhu106", 0, 3'b101, 32'h100,      32'h6,        32'h0,        6,  0, 2'b00, 32'h106,      32'h0000DEAD, 1);
    run_op("lw102",  0, 3'b010, 32'h100,      32'h2,        32'h0,        4,  1, 2'b01, 32'h102,      32'h0,        0);
    run_op("sh3ff",  1, 3'b001, 32'h400,      32'hFFFFFFFF, 32'hABCD,     0,  1, 2'b01, 32'h3FF,      32'h0,        0);
    run_op("sw3fc",  1, 3'b010, 32'h3F0,      32'hC,        32'h11223344, 0,  0, 2'b00, 32'h3FC,      32'h0,        0);
    run_op("lw3fe",  0, 3'b010, 32'h3F0,      32'hE,        32'h0,        2,  1, 2'b01, 32'h3FE,      32'h0,        0);
    run_op("lw3fc",  0, 3'b010, 32'h3F0,      32'hC,        32'h0,        9,  0, 2'b00, 32'h3FC,      32'h11223344, 1);
    run_op("lh3fe",  0, 3'b001, 32'h3FE,      32'h0,        32'h0,        0,  0, 2'b00, 32'h3FE,      32'h00001122, 0);
    run_op("lb400",  0, 3'b000, 32'h400,      32'h0,        32'h0,        1,  1, 2'b10, 32'h400,      32'h0,        0);
    run_op("sbu10",  1, 3'b100, 32'h10,       32'h0,        32'h0,        0,  1, 2'b11, 32'h10,       32'h0,        0);
    run_op("ld401",  0, 3'b011, 32'h401,      32'h0,        32'h0,        1,  1, 2'b11, 32'h401,      32'h0,        0);
    run_op("lw402",  0, 3'b010, 32'h402,      32'h0,        32'h0,        1,  1, 2'b01, 32'h402,      32'h0,        0);
    run_op("lwwrap", 0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'h0,        1,  1, 2'b10, 32'hFFFFFFFC, 32'h0,        0);

    // Backpressure: hold resp_ready low with a second request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_base = 32'h104; req_offset = 32'h0; req_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    req_funct3 = 3'b100; req_base = 32'h10; req_rd = 5'd8;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp/resp_valid", resp_valid, 1);
      check("bp/resp_data", resp_data, 32'hDEADBEEF);
      check("bp/resp_rd", resp_rd, 7);
      check("bp/resp_we", resp_we, 1);
      check("bp/req_ready", req_ready, 0);
      check("bp/strobes", mem_read | mem_write, 0);
      if (i < 4) @(posedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp/idle_ready", req_ready, 1);
    check("bp/not_yet", mem_read, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp/op2_read", mem_read, 1);
    check("bp/op2_addr", mem_addr, 32'h10);
    @(negedge clk);
    check("bp/op2_valid", resp_valid, 1);
    check("bp/op2_data", resp_data, 32'h00000080);
    check("bp/op2_rd", resp_rd, 8);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp/final_idle", req_ready, 1);

    // Reset in the ACCESS cycle of a store must abort the write.
    run_op("sw200z", 1, 3'b010, 32'h200, 32'h0, 32'h0, 0, 0, 2'b00, 32'h200, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h200; req_offset = 32'h0; req_wdata = 32'hCAFEF00D; req_rd = 5'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rsta/write_pre", mem_write, 1);
    rst = 1'b1;
    #1;
    check("rsta/write_cut", mem_write, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rsta/state", o_dbg_state, 0);
    check("rsta/req_ready", req_ready, 1);
    check("rsta/resp_valid", resp_valid, 0);
    check("rsta/mem_bytes", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'h0);
    run_op("lw200", 0, 3'b010, 32'h200, 32'h0, 32'h0, 2, 0, 2'b00, 32'h200, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, byte size of the attached data memory (legal addresses 0..MEM_BYTES-1).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  EX stage presents a memory op.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have ports req_base and req_offset  input  32 each  base register value and sign-extended immediate.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_rd  input  5  load destination register.
REQ-011 SHALL have ports mem_read, mem_write  output  1 each  data-memory strobes.
REQ-012 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_funct3  output  3  data-memory request.
REQ-013 SHALL have port mem_rdata  input  32  combinational, already-extended load data from memory.
REQ-014 SHALL have ports resp_valid  output  1, resp_ready  input  1  writeback handshake.
REQ-015 SHALL have ports resp_data  output  32, resp_rd  output  5, resp_we  output  1  (register-write enable).
REQ-016 SHALL have ports exc_valid  output  1, exc_cause  output  2 (01 misaligned, 10 out-of-range, 11 illegal funct3), exc_addr  output  32.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL, on req_valid & req_ready, register all req_* fields and effective address EA = (req_base + req_offset) mod 2^32.
REQ-019 SHALL check at accept: funct3 illegal for the op (stores: only 000/001/010) -> cause 11; else H/HU with EA[0]≠0 or W with EA[1:0]≠0 -> cause 01; else EA + size - 1 ≥ MEM_BYTES -> cause 10; priority 11 > 01 > 10.
REQ-020 SHALL go IDLE->ACCESS for a legal op, IDLE->RESP for a faulting op (no memory strobe ever issued for a fault).
REQ-021 SHALL, in ACCESS (exactly one cycle), drive mem_addr=EA, mem_funct3, mem_wdata, and assert exactly one of mem_read/mem_write; all strobes 0 in every other state.
REQ-022 SHALL capture mem_rdata at the end of ACCESS into resp_data for loads; resp_data = 0 for stores and faults.
REQ-023 SHALL hold resp_valid, resp_data, resp_rd, resp_we, exc_* stable in RESP until resp_ready; RESP->IDLE on resp_ready.
REQ-024 SHALL set resp_we = 1 only for a non-faulting load with rd ≠ 0.
REQ-025 SHALL give latency: accept at edge N, strobe during cycle N+1, resp_valid from cycle N+2 (fault: resp_valid from N+1).
REQ-026 SHALL ignore req_valid when req_ready = 0 (no queuing, no lost-state corruption).
REQ-027 SHALL assert exc_valid only together with resp_valid; exc_addr = EA of the faulting op, else 0.

Reset
REQ-028 SHALL, while rst is high at a clock edge, enter IDLE and clear resp_data, resp_rd, resp_we, exc_*, stored request fields to 0.
REQ-029 SHALL force mem_read, mem_write low combinationally while rst = 1, so reset in ACCESS aborts the store in that cycle.
REQ-030 SHALL, after reset release, present req_ready = 1, resp_valid = 0, exc_valid = 0.

Structure
REQ-031 SHALL place funct3 width codes, FSM state encoding and exc_cause codes in shared package lsu_pkg.
REQ-032 SHALL place the REQ-019 check in combinational sub-module lsu_addr_check (inputs EA, funct3, is_store; outputs fault, cause).

Verification
REQ-033 Bench SHALL cover: SW base 0x100 off 4 data 0xDEADBEEF, then LW same EA -> mem_write one cycle at 0x104, load resp_data 0xDEADBEEF, resp_we=1.
REQ-034 Bench SHALL cover: LB from byte 0x80 at EA 0x10 -> resp_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-035 Bench SHALL cover: LW at EA 0x102 -> no strobe, resp_valid at N+1, exc_cause 01, exc_addr 0x102, resp_we 0.
REQ-036 Bench SHALL cover: SH at EA 0x3FF and LW at EA 0x3FE -> cause 01; LW at EA 0x3FC ok; LB at 0x400 -> cause 10; store funct3 100 -> cause 11.
REQ-037 Bench SHALL cover: resp_ready low 5 cycles with new req_valid held -> outputs stable, req_ready 0, second op accepted only after handshake.
REQ-038 Bench SHALL cover: rst asserted during ACCESS of SW -> mem_write 0 that cycle, memory unchanged, unit in IDLE next cycle.
